// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_pkg;

  localparam int          XLEN_DEF  = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [31:0]         instr;
  } fetch_entry_t;

  // Redirect targets are word aligned; callers widen/truncate to their XLEN.
  function automatic logic [63:0] align_pc(input logic [63:0] a);
    return {a[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_prefetch_unit_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries; flush wins over push.
module fetch_fifo
  import if_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_entry_t,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  T              din,
  input  logic          pop,
  input  logic          flush,
  output T              head,
  output logic [CW-1:0] count
);

  T              mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          wr_en;

  assign wr_en = push & ~flush;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(pop);
    end
  end

endmodule

// File: rtl/if_prefetch_unit.sv
// Credit-based prefetcher for a registered-read i_mem with redirect flush.
// Optional perf counters via IF_PREFETCH_PERF_EN.
module if_prefetch_unit
  import if_pkg::*;
#(
  parameter int               XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int               DEPTH    = 2,
  parameter logic [31:0]      NOP      = NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic [31:0]     i_imem_data,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_instr_valid,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_instr_pc,
  input  logic            i_instr_ready
`ifdef IF_PREFETCH_PERF_EN
  ,
  output logic [31:0]     o_bubble_cnt,
  output logic [31:0]     o_redirect_cnt
`endif
);

  localparam int FCW = $clog2(DEPTH + 1);
  localparam int CW  = FCW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  logic [XLEN-1:0] fetch_pc, inflight_pc, redir_addr;
  logic            inflight, redir, pop, push, issue;
  logic [CW-1:0]   credit;
  logic [FCW-1:0]  count;
  entry_t          head, wdata;

  assign redir      = rst & i_redirect_valid;
  assign redir_addr = XLEN'(align_pc(64'(i_redirect_pc)));
  assign o_imem_addr = !rst  ? RESET_PC :
                       redir ? redir_addr : fetch_pc;

  assign pop    = o_instr_valid & i_instr_ready;
  assign credit = CW'(count) + CW'(inflight) - CW'(pop);
  // A redirect frees all credit (flush + discarded response), so it always issues.
  assign issue  = redir | (credit < CW'(DEPTH));
  assign push   = inflight & ~redir;
  assign wdata  = '{pc: inflight_pc, instr: i_imem_data};

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= o_imem_addr;
        fetch_pc    <= o_imem_addr + XLEN'(4);
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (wdata),
    .pop   (pop),
    .flush (redir),
    .head  (head),
    .count (count)
  );

  assign o_instr_valid = (count != '0);
  assign o_instr       = o_instr_valid ? head.instr : NOP;
  assign o_instr_pc    = o_instr_valid ? head.pc : '0;

`ifdef IF_PREFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_bubble_cnt   <= '0;
      o_redirect_cnt <= '0;
    end else begin
      if (i_instr_ready && !o_instr_valid && !(&o_bubble_cnt))
        o_bubble_cnt <= o_bubble_cnt + 32'd1;
      if (redir && !(&o_redirect_cnt))
        o_redirect_cnt <= o_redirect_cnt + 32'd1;
    end
  end
`endif

endmodule
